// File: rtl/debug_mem_dumper.sv
// debug_mem_dumper: walks data memory through its debug read port and streams every byte plus an XOR checksum to the UART TX
module debug_mem_dumper #(
    parameter int MEMORY_WIDTH = 8,
    parameter int MEMORY_DEPTH = 128,
    parameter int NB_ADDR      = 7
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [MEMORY_WIDTH-1:0] i_byte_data,
    input  logic                    i_tx_done,
    output logic                    o_read_enable,
    output logic [NB_ADDR-1:0]      o_read_address,
    output logic                    o_tx_start,
    output logic [MEMORY_WIDTH-1:0] o_tx_data,
    output logic                    o_busy,
    output logic                    o_done
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, WAIT_TX, SEND_CS, WAIT_CS, DONE} state_t;
    localparam logic [NB_ADDR-1:0] LAST = NB_ADDR'(MEMORY_DEPTH - 1);
    state_t                  state, next_state;
    logic [NB_ADDR-1:0]      counter, counter_n, address_n;
    logic [MEMORY_WIDTH-1:0] checksum, checksum_n, tx_data_n;
    logic                    last;
    assign last = counter == LAST;
    // state and registered outputs; outputs are decoded from the next state so they line up with the state they belong to
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= IDLE;
            counter        <= '0;
            checksum       <= '0;
            o_read_enable  <= 1'b0;
            o_read_address <= '0;
            o_tx_start     <= 1'b0;
            o_tx_data      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state          <= next_state;
            counter        <= counter_n;
            checksum       <= checksum_n;
            o_read_enable  <= next_state == READ;
            o_read_address <= address_n;
            o_tx_start     <= next_state == SEND || next_state == SEND_CS;
            o_tx_data      <= tx_data_n;
            o_busy         <= next_state != IDLE;
            o_done         <= next_state == DONE;
        end
    end
    // next-state sequencing of the dump
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = i_start ? READ : IDLE;
            READ:    next_state = LATCH;
            LATCH:   next_state = SEND;
            SEND:    next_state = WAIT_TX;
            WAIT_TX: next_state = i_tx_done ? (last ? SEND_CS : READ) : WAIT_TX;
            SEND_CS: next_state = WAIT_CS;
            WAIT_CS: next_state = i_tx_done ? DONE : WAIT_CS;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    // datapath next values: address counter, running checksum, transmit byte, read address
    always_comb begin
        counter_n  = state == IDLE ? '0 : (state == WAIT_TX && i_tx_done && !last) ? counter + 1'b1 : counter;
        checksum_n = state == IDLE ? '0 : state == LATCH ? checksum ^ i_byte_data : checksum;
        tx_data_n  = state == LATCH ? i_byte_data : next_state == SEND_CS ? checksum : o_tx_data;
        address_n  = next_state == READ ? counter_n : o_read_address;
    end
endmodule

// File: tb/tb_debug_mem_dumper.sv
// tb_debug_mem_dumper: scoreboard bench with memory and UART TX models around debug_mem_dumper
module tb_debug_mem_dumper;
    logic       clk = 0;
    logic       i_reset = 1, i_start = 0, i_tx_done = 0;
    logic [7:0] i_byte_data = 0;
    logic       o_read_enable, o_tx_start, o_busy, o_done;
    logic [6:0] o_read_address;
    logic [7:0] o_tx_data;
    logic [7:0] mem [128];
    logic [7:0] q [$];
    logic [7:0] last_tx;
    int checks = 0, failures = 0;
    int cyc = 0, first_rd = -1, done_cyc = 0, done_cnt = 0, tx_cnt = 0, rd_cnt = 0, viol = 0;
    int tx_delay = 1, cd = 0;
    bit spur = 0, pend = 0;

    debug_mem_dumper dut (
        .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_byte_data(i_byte_data),
        .i_tx_done(i_tx_done), .o_read_enable(o_read_enable), .o_read_address(o_read_address),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // memory model: one-cycle read latency, data present during LATCH
    always @(negedge clk) if (o_read_enable) i_byte_data = mem[o_read_address];

    // UART TX model: done tx_delay cycles after tx_start, optional spurious done alongside tx_start
    always @(negedge clk) begin
        i_tx_done = 0;
        if (spur && o_tx_start) i_tx_done = 1;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin i_tx_done = 1; pend = 0; end
        end
        if (o_tx_start) cd = tx_delay;
    end

    // output monitor: scoreboard pop on every tx_start, event counters
    always @(negedge clk) begin
        cyc++;
        if (o_read_enable) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            if (pend) viol++;
        end
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_tx_start) begin
            tx_cnt++;
            last_tx = o_tx_data;
            pend = 1;
            check("q_avail", q.size() > 0, 1);
            if (q.size() > 0) check("tx_byte", o_tx_data, q.pop_front());
        end
    end

    task automatic run_dump(input int dly, input bit sp, input bit midstart, input int exp_cycles);
        logic [7:0] cs = 0;
        bit         restarted = 0;
        tx_delay = dly; spur = sp; done_cnt = 0; tx_cnt = 0; viol = 0; first_rd = -1;
        for (int i = 0; i < 128; i++) begin q.push_back(mem[i]); cs ^= mem[i]; end
        q.push_back(cs);
        @(negedge clk) i_start = 1;
        @(negedge clk) i_start = 0;
        check("busy_rise", {o_busy, o_read_enable, o_read_address}, {2'b11, 7'd0});
        for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
            @(negedge clk);
            i_start = 0;
            if (midstart && !restarted && tx_cnt == 40) begin i_start = 1; restarted = 1; end
        end
        i_start = 0;
        check("done_seen", done_cnt > 0, 1);
        repeat (5) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("q_empty", q.size(), 0);
        check("tx_count", tx_cnt, 129);
        check("idle_after", {o_busy, o_done}, 0);
        check("final_cs", last_tx, cs);
        check("rd_vs_done", viol, 0);
        if (exp_cycles > 0) check("dump_cycles", done_cyc - first_rd + 1, exp_cycles);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        i_reset = 0;
        @(negedge clk);
        check("rst_outs", {o_read_enable, o_read_address, o_tx_start, o_tx_data, o_busy, o_done}, 0);
        repeat (10) @(negedge clk);
        check("idle_no_rd", rd_cnt, 0);
        check("idle_outs", {o_read_enable, o_tx_start, o_busy, o_done}, 0);

        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        run_dump(1, 0, 0, 4 * 128 + 3);
        check("ramp_cs_zero", last_tx, 8'h00);

        run_dump(10, 1, 0, 0);

        for (int i = 0; i < 128; i++) mem[i] = 0;
        mem[0] = 8'h5A; mem[1] = 8'hFF;
        run_dump(1, 0, 0, 0);
        check("cs_a5", last_tx, 8'hA5);

        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        run_dump(2, 0, 1, 0);

        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        for (int i = 0; i < 128; i++) q.push_back(mem[i]);
        tx_delay = 10; spur = 0; tx_cnt = 0; done_cnt = 0;
        @(negedge clk) i_start = 1;
        @(negedge clk) i_start = 0;
        for (int c = 0; c < 5000 && tx_cnt < 64; c++) @(negedge clk);
        check("reached_63", tx_cnt, 64);
        @(negedge clk);
        i_reset = 1;
        @(negedge clk);
        check("midrst_outs", {o_read_enable, o_read_address, o_tx_start, o_tx_data, o_busy, o_done}, 0);
        i_reset = 0;
        q.delete();
        cd = 0; pend = 0;
        repeat (30) @(negedge clk);
        check("no_done_after_rst", done_cnt, 0);
        check("no_tx_after_rst", tx_cnt, 64);
        run_dump(1, 0, 0, 4 * 128 + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
